// File: rtl/cfg_shift_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cfg_shift_pkg
// Description : Shared constants for the cipher configuration shift chain.
//               It holds the chain length, the field layout of the 259-bit
//               configuration word, the target's reset defaults and the
//               master FSM state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package cfg_shift_pkg;

  // Chain length and bit-counter width
  localparam int CFG_W = 259;
  localparam int CNT_W = $clog2(CFG_W);

  // Field layout of the configuration word (LSB positions)
  localparam int FIELD_W      = 64;
  localparam int K_MUX_BIT    = 258;
  localparam int A_MUX_BIT    = 257;
  localparam int D_EN_BIT     = 256;
  localparam int TX_TAPS_LSB  = 192;
  localparam int TX_STATE_LSB = 128;
  localparam int RX_TAPS_LSB  = 64;
  localparam int RX_STATE_LSB = 0;

  // Target register contents after its own reset
  localparam logic [FIELD_W-1:0] DEFAULT_TAPS  = 64'h48000000;
  localparam logic [FIELD_W-1:0] DEFAULT_STATE = 64'h55;

  // Master FSM encoding; GAP and VERIFY are only reachable in verify builds
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_SHIFT  = 3'd1;
  localparam logic [2:0] ST_DONE   = 3'd2;
  localparam logic [2:0] ST_GAP    = 3'd3;
  localparam logic [2:0] ST_VERIFY = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE   = ST_IDLE,
    S_SHIFT  = ST_SHIFT,
    S_DONE   = ST_DONE,
    S_GAP    = ST_GAP,
    S_VERIFY = ST_VERIFY
  } state_e;

  // Default word held by a freshly reset target
  function automatic logic [CFG_W-1:0] default_cfg();
    return {1'b0, 1'b0, 1'b0, DEFAULT_TAPS, DEFAULT_STATE, DEFAULT_TAPS, DEFAULT_STATE};
  endfunction

endpackage
`default_nettype wire

// File: rtl/cfg_shift_counter.sv
`default_nettype none
// ============================================================================
// Module      : cfg_shift_counter
// Description : Bit counter for one configuration pass. Counts enabled
//               cycles from 0 and flags the terminal count CFG_W-1.
// Ports       : clk, rst - clock and synchronous active-high reset
//               clr      - synchronous clear (priority over en)
//               en       - count enable
//               tc       - high while the count equals CFG_W-1
// Revision    : 1.0 - initial release
// ============================================================================
module cfg_shift_counter
  import cfg_shift_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(CFG_W - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign tc = (cnt == LAST);

endmodule
`default_nettype wire

// File: rtl/cfg_shift_master.sv
`default_nettype none
// ============================================================================
// Module      : cfg_shift_master
// Description : Host-side initiator for the cipher serial configuration
//               chain. It shifts a parallel CFG_W-bit word out LSB first on
//               cfg_i while cfg_en is high. At the same time it collects the
//               target's previous contents from cfg_o into cfg_rdata.
//               Build option CFG_SHIFT_VERIFY_EN adds a read-back verify pass
//               that raises the sticky flag verify_err on any mismatch.
// Ports       : clk, rst     - clock, synchronous active-high reset
//               start        - pass request, sampled only in IDLE
//               cfg_wdata    - word to program, captured on accepted start
//               busy         - high whenever a pass is in progress
//               done         - one-cycle completion pulse
//               cfg_rdata    - target contents read back during last pass
//               verify_err   - sticky verify mismatch (0 without the macro)
//               cfg_en/cfg_i - shift enable and serial data to the target
//               cfg_o        - serial data returned by the target
// Revision    : 1.0 - initial release
// ============================================================================
module cfg_shift_master
  import cfg_shift_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CFG_W-1:0] cfg_wdata,
  output logic             busy,
  output logic             done,
  output logic [CFG_W-1:0] cfg_rdata,
  output logic             verify_err,
  output logic             cfg_en,
  output logic             cfg_i,
  input  logic             cfg_o
);

  logic [2:0]       state;
  logic [CFG_W-1:0] shreg;
  logic [CFG_W-1:0] rb;
  logic             shifting;
  logic             cnt_tc;

`ifdef CFG_SHIFT_VERIFY_EN
  logic [CFG_W-1:0] wword;
  logic             verr;
  assign shifting = (state == ST_SHIFT) || (state == ST_VERIFY);
`else
  assign shifting = (state == ST_SHIFT);
`endif

  // Serial outputs depend only on registered state, never on live inputs
  assign cfg_en = shifting;
  assign cfg_i  = shifting & shreg[0];
  assign busy   = (state != ST_IDLE);
  assign done   = (state == ST_DONE);

  // The counter is held clear outside shifting states, so every run starts at 0
  cfg_shift_counter u_counter (
    .clk (clk),
    .rst (rst),
    .clr (!shifting),
    .en  (shifting),
    .tc  (cnt_tc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      shreg     <= '0;
      rb        <= '0;
      cfg_rdata <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            shreg <= cfg_wdata;
            state <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          shreg <= {1'b0, shreg[CFG_W-1:1]};
          rb    <= {cfg_o, rb[CFG_W-1:1]};
          if (cnt_tc) begin
            // Fold in the final bit directly; rb itself is one bit behind here
            cfg_rdata <= {cfg_o, rb[CFG_W-1:1]};
`ifdef CFG_SHIFT_VERIFY_EN
            state     <= ST_GAP;
`else
            state     <= ST_DONE;
`endif
          end
        end
`ifdef CFG_SHIFT_VERIFY_EN
        ST_GAP: begin
          // Reload the held word. The target now presents it from bit 0.
          shreg <= wword;
          state <= ST_VERIFY;
        end
        ST_VERIFY: begin
          // Rewriting the same word leaves the target holding it after verify
          shreg <= {1'b0, shreg[CFG_W-1:1]};
          if (cnt_tc) begin
            state <= ST_DONE;
          end
        end
`endif
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef CFG_SHIFT_VERIFY_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      wword <= '0;
      verr  <= 1'b0;
    end else if ((state == ST_IDLE) && start) begin
      wword <= cfg_wdata;
      verr  <= 1'b0;
    end else if ((state == ST_VERIFY) && (cfg_o != shreg[0])) begin
      verr  <= 1'b1;
    end
  end

  assign verify_err = verr;
`else
  assign verify_err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_cfg_shift_master.sv
`default_nettype none
// ============================================================================
// Module      : tb_cfg_shift_master
// Description : Self-checking bench for cfg_shift_master. It pairs the DUT
//               with a behavioural chain target and compares the DUT against
//               expectations taken from the pass timing rules. The same file
//               covers the CFG_SHIFT_VERIFY_EN build.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cfg_shift_master;
  import cfg_shift_pkg::CFG_W;

  localparam int W = CFG_W;
`ifdef CFG_SHIFT_VERIFY_EN
  localparam bit VERIFY = 1'b1;
`else
  localparam bit VERIFY = 1'b0;
`endif
  // Cycle (counted from the accepting edge) on which done is expected
  localparam int LAT = VERIFY ? (2 * W + 2) : (W + 1);

  localparam logic [W-1:0] TGT_DEFAULT =
    {3'b000, 64'h48000000, 64'h55, 64'h48000000, 64'h55};
  localparam logic [W-1:0] W_DIRECTED =
    {3'b101, 64'hDEADBEEF00000001, 64'h1, 64'hA5A5A5A5A5A5A5A5, 64'h0F};

  logic           clk;
  logic           rst;
  logic           start;
  logic [W-1:0]   cfg_wdata;
  logic           busy;
  logic           done;
  logic [W-1:0]   cfg_rdata;
  logic           verify_err;
  logic           cfg_en;
  logic           cfg_i;
  logic           cfg_o;

  int checks = 0;
  int errors = 0;

  cfg_shift_master dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .cfg_wdata  (cfg_wdata),
    .busy       (busy),
    .done       (done),
    .cfg_rdata  (cfg_rdata),
    .verify_err (verify_err),
    .cfg_en     (cfg_en),
    .cfg_i      (cfg_i),
    .cfg_o      (cfg_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural chain target: a plain shift register that moves toward bit 0
  logic [W-1:0] tgt;
  logic         tgt_load;
  logic         stuck;

  always @(posedge clk) begin
    if (tgt_load)    tgt <= TGT_DEFAULT;
    else if (cfg_en) tgt <= {cfg_i, tgt[W-1:1]};
  end
  assign cfg_o = stuck ? 1'b0 : tgt[0];

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] rand_word();
    logic [W-1:0] r = '0;
    for (int i = 0; i < 9; i++) r = (r << 32) | W'($urandom);
    return r;
  endfunction

  // Expected enable window(s) relative to the accepting edge
  function automatic bit exp_en(input int c);
    if (c >= 1 && c <= W) return 1'b1;
    if (VERIFY && c >= W + 2 && c <= 2 * W + 1) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic exp_bit(input logic [W-1:0] w, input int c);
    if (c <= W) return w[c-1];
    return w[c-W-2];
  endfunction

  // Runs one pass from the current negedge (DUT idle at the next edge).
  // It returns on the first idle cycle after done. With hold set, start stays
  // high so that a following call begins back-to-back.
  task automatic run_pass(input logic [W-1:0] w, input int pulse_at,
                          input bit hold, input bit stuck_o);
    logic [W-1:0] exp_rd;
    logic         exp_verr;
    stuck     = stuck_o;
    exp_rd    = stuck_o ? '0 : tgt;
    exp_verr  = VERIFY && stuck_o && (w != '0);
    start     = 1'b1;
    cfg_wdata = w;
    for (int c = 1; c <= LAT; c++) begin
      @(negedge clk);
      check("cfg_en", W'(cfg_en), W'(exp_en(c)));
      if (exp_en(c)) check("cfg_i", W'(cfg_i), W'(exp_bit(w, c)));
      check("done", W'(done), W'(c == LAT));
      check("busy", W'(busy), W'(1));
      if (c == 1) check("verify_err_clr", W'(verify_err), W'(0));
      if (!hold) begin
        start     = (c == pulse_at);
        cfg_wdata = rand_word();
      end
    end
    check("cfg_rdata", cfg_rdata, exp_rd);
    check("verify_err", W'(verify_err), W'(exp_verr));
    @(negedge clk);
    check("idle_busy", W'(busy), W'(0));
    check("idle_en", W'(cfg_en), W'(0));
    check("target", tgt, w);
    if (!hold) begin
      start = 1'b0;
      for (int i = 0; i < 3; i++) begin
        @(negedge clk);
        check("post_busy", W'(busy), W'(0));
        check("post_done", W'(done), W'(0));
        check("post_verr", W'(verify_err), W'(exp_verr));
      end
    end
  endtask

  initial begin
    logic [W-1:0] w1;
    bit           quiet;
    rst       = 1'b1;
    start     = 1'b0;
    cfg_wdata = '0;
    stuck     = 1'b0;
    tgt_load  = 1'b1;
    repeat (3) @(negedge clk);
    rst      = 1'b0;
    tgt_load = 1'b0;

    // Reset state held through 10 idle cycles
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("rst_en", W'(cfg_en), W'(0));
      check("rst_busy", W'(busy), W'(0));
      check("rst_done", W'(done), W'(0));
      check("rst_rdata", cfg_rdata, '0);
      check("rst_verr", W'(verify_err), W'(0));
    end

    // Directed word against a freshly reset target
    check("tgt_default", tgt, TGT_DEFAULT);
    run_pass(W_DIRECTED, -1, 1'b0, 1'b0);

    // Second start pulse mid-pass must be ignored
    run_pass(rand_word(), 5, 1'b0, 1'b0);

    // Reset at cycle 100 of SHIFT
    start     = 1'b1;
    cfg_wdata = rand_word();
    @(negedge clk);
    start     = 1'b0;
    repeat (99) @(negedge clk);
    check("pre_rst_en", W'(cfg_en), W'(1));
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_en", W'(cfg_en), W'(0));
    check("midrst_busy", W'(busy), W'(0));
    check("midrst_done", W'(done), W'(0));
    check("midrst_rdata", cfg_rdata, '0);
    quiet = 1'b1;
    for (int i = 0; i < W + 5; i++) begin
      @(negedge clk);
      if (done || cfg_en || busy) quiet = 1'b0;
    end
    check("midrst_quiet", W'(quiet), W'(1));
    run_pass(rand_word(), -1, 1'b0, 1'b0);

    // Back-to-back with start held; second readback is the first word
    w1 = rand_word();
    run_pass(w1, -1, 1'b1, 1'b0);
    run_pass(rand_word(), -1, 1'b0, 1'b0);
    check("b2b_rdata_src", tgt == w1 ? W'(0) : W'(1), W'(1));

    // A few more random passes
    for (int n = 0; n < 3; n++) run_pass(rand_word(), -1, 1'b0, 1'b0);

`ifdef CFG_SHIFT_VERIFY_EN
    // Stuck-at-0 readback with bit 0 set must flag, then clear on next start
    w1 = rand_word() | W'(1);
    run_pass(w1, -1, 1'b0, 1'b1);
    check("stuck_flag", W'(verify_err), W'(1));
    run_pass(rand_word(), -1, 1'b0, 1'b0);
    check("flag_cleared", W'(verify_err), W'(0));
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Absolute bound so the run always terminates
  initial begin
    #(100000 * 10);
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
